// File: rtl/quad_1x2_demux_fifo.sv
// Registered 1-to-2 demux steering one valid/ready stream into two FIFO channels.
// Define DEMUX_COUNT_EN to add saturating per-channel pop counters (a_count, b_count).
module quad_1x2_demux_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset_b,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_sel,
    input  logic [W-1:0] in_data,
    output logic         a_valid,
    input  logic         a_ready,
    output logic [W-1:0] a_data,
    output logic         b_valid,
    input  logic         b_ready,
`ifdef DEMUX_COUNT_EN
    output logic [W-1:0] b_data,
    output logic [7:0]   a_count,
    output logic [7:0]   b_count
`else
    output logic [W-1:0] b_data
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // channel index 0 is a, 1 is b
    logic [W-1:0]  mem [2][DEPTH];
    logic [AW-1:0] wp  [2];
    logic [AW-1:0] rp  [2];
    logic [AW:0]   cnt [2];

    logic [1:0] vld;
    logic [1:0] rdy;
    logic [1:0] full;
    logic [1:0] push;
    logic [1:0] pop;
    logic       acc;

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            vld[c]  = (cnt[c] != '0);
            full[c] = (cnt[c] == FULL_CNT);
        end
    end

    assign rdy      = {b_ready, a_ready};
    assign in_ready = in_sel ? !full[0] : !full[1];
    assign acc      = in_valid & in_ready;
    assign push     = {acc & !in_sel, acc & in_sel};
    assign pop      = vld & rdy;

    assign a_valid = vld[0];
    assign b_valid = vld[1];
    assign a_data  = mem[0][rp[0]];
    assign b_data  = mem[1][rp[1]];

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            for (int c = 0; c < 2; c++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[c][i] <= '0;
                end
                wp[c]  <= '0;
                rp[c]  <= '0;
                cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (push[c]) begin
                    mem[c][wp[c]] <= in_data;
                    wp[c]         <= wp[c] + AW'(1);
                end
                if (pop[c]) begin
                    rp[c] <= rp[c] + AW'(1);
                end
                if (push[c] && !pop[c]) begin
                    cnt[c] <= cnt[c] + (AW+1)'(1);
                end else if (!push[c] && pop[c]) begin
                    cnt[c] <= cnt[c] - (AW+1)'(1);
                end
            end
        end
    end

`ifdef DEMUX_COUNT_EN
    logic [7:0] pops [2];

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            pops[0] <= '0;
            pops[1] <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (pop[c] && pops[c] != 8'hff) begin
                    pops[c] <= pops[c] + 8'd1;
                end
            end
        end
    end

    assign a_count = pops[0];
    assign b_count = pops[1];
`endif

endmodule

// File: tb/tb_quad_1x2_demux_fifo.sv
// Directed self-checking bench for quad_1x2_demux_fifo.
// Hand-computed expectations for steering, backpressure, wrap and reset.
module tb_quad_1x2_demux_fifo;

    logic       clock = 1'b0;
    logic       reset_b;
    logic       in_valid;
    logic       in_ready;
    logic       in_sel;
    logic [3:0] in_data;
    logic       a_valid;
    logic       a_ready;
    logic [3:0] a_data;
    logic       b_valid;
    logic       b_ready;
    logic [3:0] b_data;
`ifdef DEMUX_COUNT_EN
    logic [7:0] a_count;
    logic [7:0] b_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    quad_1x2_demux_fifo #(.W(4), .DEPTH(2)) dut (
        .clock   (clock),
        .reset_b (reset_b),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_sel  (in_sel),
        .in_data (in_data),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_data  (a_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
`ifdef DEMUX_COUNT_EN
        .b_data  (b_data),
        .a_count (a_count),
        .b_count (b_count)
`else
        .b_data  (b_data)
`endif
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic sel, input logic [3:0] d);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset_b  = 1'b0;
        in_valid = 1'b0;
        in_sel   = 1'b0;
        in_data  = '0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        tick();
        tick();
        reset_b = 1'b1;
        #1;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_a_valid", a_valid, 0);
        check_eq("rst_b_valid", b_valid, 0);
        check_eq("rst_a_data", a_data, 0);
        check_eq("rst_b_data", b_data, 0);

        // basic steer
        push(1'b1, 4'b0101);
        #1;
        check_eq("steer_a_valid", a_valid, 1);
        check_eq("steer_a_data", a_data, 5);
        check_eq("steer_b_valid", b_valid, 0);
        push(1'b0, 4'b1010);
        #1;
        check_eq("steer_b_valid", b_valid, 1);
        check_eq("steer_b_data", b_data, 10);
        check_eq("steer_a_hold", a_data, 5);
        a_ready = 1'b1;
        b_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        b_ready = 1'b0;
        #1;
        check_eq("drain_a_valid", a_valid, 0);
        check_eq("drain_b_valid", b_valid, 0);

        // backpressure on a
        push(1'b1, 4'b0001);
        push(1'b1, 4'b0010);
        in_sel = 1'b1;
        #1;
        check_eq("bp_full_a", in_ready, 0);
        in_sel = 1'b0;
        #1;
        check_eq("bp_b_open", in_ready, 1);
        push(1'b0, 4'b0011);
        #1;
        check_eq("bp_b_data", b_data, 3);
        check_eq("bp_a_hold", a_data, 1);
        a_ready = 1'b1;
        #1;
        check_eq("bp_a_first", a_data, 1);
        tick();
        check_eq("bp_a_second", a_data, 2);
        check_eq("bp_a_valid2", a_valid, 1);
        tick();
        check_eq("bp_a_empty", a_valid, 0);
        a_ready = 1'b0;
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        #1;
        check_eq("bp_b_empty", b_valid, 0);

        // simultaneous push and pop
        push(1'b1, 4'b0110);
        a_ready = 1'b1;
        push(1'b1, 4'b0111);
        a_ready = 1'b0;
        #1;
        check_eq("sim_a_valid", a_valid, 1);
        check_eq("sim_a_data", a_data, 7);
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        check_eq("sim_occ_one", a_valid, 0);

        // full channel with pop: no pass-through push
        push(1'b1, 4'b1000);
        push(1'b1, 4'b1001);
        a_ready  = 1'b1;
        in_valid = 1'b1;
        in_sel   = 1'b1;
        in_data  = 4'b1111;
        #1;
        check_eq("full_pop_rdy", in_ready, 0);
        tick();
        in_valid = 1'b0;
        a_ready  = 1'b0;
        #1;
        check_eq("full_pop_head", a_data, 9);
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        check_eq("full_no_push", a_valid, 0);

        // wrap-around stream
        a_ready = 1'b1;
        b_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(i[0], 4'(i));
            #1;
            if (i[0]) begin
                check_eq("wrap_a_data", a_data, i);
                check_eq("wrap_a_valid", a_valid, 1);
                check_eq("wrap_b_idle", b_valid, 0);
            end else begin
                check_eq("wrap_b_data", b_data, i);
                check_eq("wrap_b_valid", b_valid, 1);
                check_eq("wrap_a_idle", a_valid, 0);
            end
        end
        tick();
        check_eq("wrap_a_done", a_valid, 0);
        check_eq("wrap_b_done", b_valid, 0);
        a_ready = 1'b0;
        b_ready = 1'b0;

        // reset mid-stream
        push(1'b1, 4'b0001);
        push(1'b0, 4'b0010);
        push(1'b1, 4'b0011);
        in_sel = 1'b1;
        #1;
        check_eq("mid_full", in_ready, 0);
        #2;
        reset_b = 1'b0;
        #1;
        check_eq("mid_in_ready", in_ready, 1);
        check_eq("mid_a_valid", a_valid, 0);
        check_eq("mid_b_valid", b_valid, 0);
        check_eq("mid_a_data", a_data, 0);
        check_eq("mid_b_data", b_data, 0);
        tick();
        reset_b = 1'b1;
        #1;
        check_eq("post_rst_a", a_valid, 0);

`ifdef DEMUX_COUNT_EN
        check_eq("cnt_rst_b", b_count, 0);
        b_ready  = 1'b1;
        in_valid = 1'b1;
        in_sel   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_data = 4'(i);
            tick();
        end
        check_eq("cnt_b_9", b_count, 9);
        for (int i = 0; i < 291; i++) begin
            in_data = 4'(i);
            tick();
        end
        in_valid = 1'b0;
        b_ready  = 1'b0;
        #1;
        check_eq("cnt_b_sat", b_count, 255);
        check_eq("cnt_a_zero", a_count, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
